// File: rtl/exe_stage.sv
// Execute stage of the in-order pipeline: single-cycle ALU, data SRAM request, decode forwarding.
// Optional two-cycle mul.w support is enabled by defining the macro EXE_MUL_EN.
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    input  logic [31:0] ds_pc,
    input  logic [31:0] ds_alu_src1,
    input  logic [31:0] ds_alu_src2,
    input  logic [31:0] ds_st_data,
    input  logic [11:0] ds_alu_op,
    input  logic        ds_sram_en,
    input  logic [3:0]  ds_sram_we,
    input  logic        ds_mul,
    input  logic [3:0]  ds_rf_we,
    input  logic [4:0]  ds_rf_waddr,
    input  logic        ms_allow_in,
    output logic        es_allow_in,
    output logic        es_to_ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_alu_result,
    output logic [3:0]  es_rf_we,
    output logic [4:0]  es_rf_waddr,
    output logic        es_res_from_mem,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic [3:0]  es_fwd_we,
    output logic [4:0]  es_fwd_waddr,
    output logic [31:0] es_fwd_wdata
);

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        es_valid_r;
    logic [31:0] pc_r;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic [31:0] st_data_r;
    logic [11:0] op_r;
    logic        sram_en_r;
    logic [3:0]  sram_we_r;
    logic [3:0]  rf_we_r;
    logic [4:0]  rf_waddr_r;

    logic        es_ready_go_s;
    logic        load_s;
    logic        mem_access_s;
    logic [31:0] alu_s;
    logic [31:0] result_s;

    // Shared adder/subtractor outputs feeding add, sub, slt and sltu
    logic [31:0] add_sum_s;
    logic [32:0] sub_full_s;
    logic        slt_s;
    logic        sltu_s;

    assign load_s       = ds_to_es_valid & es_allow_in;
    assign es_allow_in  = ~es_valid_r | (es_ready_go_s & ms_allow_in);
    assign es_to_ms_valid = es_valid_r & es_ready_go_s;

    // Stage occupancy flag; follows decode whenever the slot is free or draining
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_r <= 1'b0;
        end else if (es_allow_in) begin
            es_valid_r <= ds_to_es_valid;
        end
    end

    // Instruction payload captured only on an accepted handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            src1_r     <= 32'd0;
            src2_r     <= 32'd0;
            st_data_r  <= 32'd0;
            op_r       <= 12'd0;
            sram_en_r  <= 1'b0;
            sram_we_r  <= 4'd0;
            rf_we_r    <= 4'd0;
            rf_waddr_r <= 5'd0;
        end else if (load_s) begin
            pc_r       <= ds_pc;
            src1_r     <= ds_alu_src1;
            src2_r     <= ds_alu_src2;
            st_data_r  <= ds_st_data;
            op_r       <= ds_alu_op;
            sram_en_r  <= ds_sram_en;
            sram_we_r  <= ds_sram_we;
            rf_we_r    <= ds_rf_we;
            rf_waddr_r <= ds_rf_waddr;
        end
    end

    assign add_sum_s  = src1_r + src2_r;
    assign sub_full_s = {1'b0, src1_r} + {1'b0, ~src2_r} + 33'd1;
    // Signed less-than: differing signs decide directly, equal signs use the difference sign
    assign slt_s  = (src1_r[31] & ~src2_r[31]) |
                    (~(src1_r[31] ^ src2_r[31]) & sub_full_s[31]);
    assign sltu_s = ~sub_full_s[32];

    // One-hot operation select; an all-zero opcode yields zero
    always_comb begin
        alu_s = 32'd0;
        alu_s = alu_s | ({32{op_r[0]}}  & add_sum_s);
        alu_s = alu_s | ({32{op_r[1]}}  & sub_full_s[31:0]);
        alu_s = alu_s | ({32{op_r[2]}}  & {31'd0, slt_s});
        alu_s = alu_s | ({32{op_r[3]}}  & {31'd0, sltu_s});
        alu_s = alu_s | ({32{op_r[4]}}  & (src1_r & src2_r));
        alu_s = alu_s | ({32{op_r[5]}}  & ~(src1_r | src2_r));
        alu_s = alu_s | ({32{op_r[6]}}  & (src1_r | src2_r));
        alu_s = alu_s | ({32{op_r[7]}}  & (src1_r ^ src2_r));
        alu_s = alu_s | ({32{op_r[8]}}  & (src1_r << src2_r[4:0]));
        alu_s = alu_s | ({32{op_r[9]}}  & (src1_r >> src2_r[4:0]));
        alu_s = alu_s | ({32{op_r[10]}} & 32'($signed(src1_r) >>> src2_r[4:0]));
        alu_s = alu_s | ({32{op_r[11]}} & src2_r);
    end

`ifdef EXE_MUL_EN
    logic        mul_r;
    logic        mul_done_r;
    logic [31:0] prod_r;

    // Mul flag travels with the payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_r <= 1'b0;
        end else if (load_s) begin
            mul_r <= ds_mul;
        end
    end

    // First mul cycle latches the low product; done clears when the slot turns over
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_done_r <= 1'b0;
            prod_r     <= 32'd0;
        end else if (es_allow_in) begin
            mul_done_r <= 1'b0;
        end else if (es_valid_r & mul_r & ~mul_done_r) begin
            prod_r     <= src1_r * src2_r;
            mul_done_r <= 1'b1;
        end
    end

    assign es_ready_go_s = ~mul_r | mul_done_r;
    assign result_s      = mul_r ? prod_r : alu_s;
`else
    logic unused_mul_s;

    assign unused_mul_s  = ds_mul;
    assign es_ready_go_s = 1'b1;
    assign result_s      = alu_s;
`endif

    // Memory request fires only in the cycle the instruction actually moves on
    assign mem_access_s    = es_to_ms_valid & ms_allow_in & (sram_en_r | (sram_we_r != 4'd0));
    assign data_sram_en    = mem_access_s;
    assign data_sram_we    = mem_access_s ? sram_we_r : 4'd0;
    assign data_sram_addr  = add_sum_s;
    assign data_sram_wdata = st_data_r;

    assign es_pc           = pc_r;
    assign es_alu_result   = result_s;
    assign es_rf_we        = rf_we_r;
    assign es_rf_waddr     = rf_waddr_r;
    assign es_res_from_mem = sram_en_r;

    // Loads and unfinished muls have no usable value to forward yet
    assign es_fwd_we    = (es_valid_r & ~sram_en_r & es_ready_go_s) ? rf_we_r : 4'd0;
    assign es_fwd_waddr = rf_waddr_r;
    assign es_fwd_wdata = result_s;

endmodule
